wb_rr_arbiter: RTL
==================

// Module: wb_rr_arbiter
// PURPOSE
//  N-master to 1-slave Wishbone B4 classic arbiter sharing the user-project peripheral bus
//  (timer/PWM, UART, SRAM decode) between the management SoC and on-chip masters (e.g. DMA).
//  Round-robin grant per bus cycle; grant held for the whole CYC (locked burst).
//  A watchdog ends stalled transfers with ERR so one hung slave cannot freeze the bus.
// PARAMETERS
//  N        2      number of masters, 2..8
//  TIMEOUT  255    max wait cycles for slave ACK per beat; 0 disables the watchdog
// PORTS
//  wb_clk_i      in   1      bus clock, all logic on rising edge
//  wb_rst_i      in   1      asynchronous active-high reset
//  m_cyc_i       in   N      per-master CYC
//  m_stb_i       in   N      per-master STB
//  m_we_i        in   N      per-master WE
//  m_sel_i       in   4*N    per-master SEL, master k at [4k+3:4k]
//  m_adr_i       in   32*N   per-master ADR, master k at [32k+31:32k]
//  m_dat_i       in   32*N   per-master write data, same packing as ADR
//  m_ack_o       out  N      ACK, only the granted master's bit can be 1
//  m_err_o       out  N      ERR on watchdog expiry, granted master only
//  m_dat_o       out  32     read data broadcast to all; valid only with own ACK/ERR
//  s_cyc_o       out  1      slave CYC
//  s_stb_o       out  1      slave STB
//  s_we_o        out  1      slave WE
//  s_sel_o       out  4      slave SEL
//  s_adr_o       out  32     slave ADR
//  s_dat_o       out  32     slave write data
//  s_ack_i       in   1      slave ACK
//  s_dat_i       in   32     slave read data
//  grant_o       out  N      one-hot current grant, 0 in IDLE
//  timeout_irq_o out  1      one-cycle pulse per watchdog expiry
// BEHAVIOUR
//  Reset: state IDLE, grant 0, last_grant = N-1 (master 0 wins first), watchdog 0; every
//   output 0; m_dat_o 0.
//  FSM IDLE: req[k] = m_cyc_i[k] & m_stb_i[k]. If any req, pick the first requester scanning
//   last_grant+1, +2, ... mod N. Register grant and last_grant, go to GRANT. Nothing reaches
//   the slave in IDLE.
//  FSM GRANT: slave outputs combinationally mirror granted master g. s_cyc_o = m_cyc_i[g],
//   s_stb_o = m_stb_i[g] & ~expire. m_ack_o[g] = s_ack_i; m_dat_o = s_dat_i.
//   Arbitration latency: 1 cycle from request to slave STB.
//  Release: m_cyc_i[g] sampled low in GRANT -> IDLE next cycle, grant cleared.
//   One dead cycle between owners. A new grant is issued from IDLE the cycle after.
//  Lock: while m_cyc_i[g] is high the grant never changes, whatever other requests arrive.
//  Watchdog: wd counts cycles with s_stb_o=1 & s_ack_i=0. Cleared on ACK, on STB low and in IDLE.
//   Width $clog2(TIMEOUT+1), saturating, never wraps.
//  Expiry: wd == TIMEOUT while stalled. That cycle: m_err_o[g]=1, m_dat_o=32'hDEADBEEF,
//   s_stb_o forced 0, timeout_irq_o=1, m_ack_o[g]=0, wd cleared. Grant stays; master may retry.
//  Simultaneous s_ack_i and expiry: ACK wins, no ERR and no IRQ.
//  TIMEOUT=0: no ERR and no IRQ ever.
//  Slave ACK while in IDLE or with STB low: ignored, no m_ack_o.
//  Requester drops STB before grant: no transfer. Its req is simply not seen at the next
//   arbitration.
//  Async reset mid-transfer: all outputs drop immediately. The in-flight beat is abandoned.
//  ACK/ERR/IRQ are never asserted to any non-granted master.
// TESTING
//  1 Reset: assert wb_rst_i mid-burst -> all outputs 0 same cycle. Release; m0,m1 request
//    together -> grant_o=01, s_stb_o high 1 cycle after req.
//  2 Round-robin: N=3, all masters issue repeated single reads (CYC drops after each ACK).
//    -> grant order 0,1,2,0,1,2 with one IDLE cycle between.
//  3 Lock: m0 holds CYC for a 4-beat write burst while m1 requests -> m1 gets no grant until
//    m0 drops CYC. Slave sees 4 writes with m0 ADR/DAT/SEL exactly.
//  4 Timeout: TIMEOUT=8, slave never ACKs -> m_err_o[g] and timeout_irq_o pulse on cycle 9
//    of STB, m_dat_o=DEADBEEF, s_stb_o low that cycle.
//  5 Race: s_ack_i asserted exactly on the expiry cycle -> ACK only, no ERR/IRQ, s_dat_i
//    returned to the master.
//  6 Isolation: random s_ack_i glitches in IDLE and on non-granted masters -> m_ack_o stays 0.
//    Checker asserts grant_o is one-hot or zero every cycle.

Source files
------------

// File: rtl/wb_rr_arbiter_if.sv
// Bus bundle between N Wishbone masters, the round-robin arbiter and the shared slave.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface wb_rr_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]    m_cyc_i;
  logic [N-1:0]    m_stb_i;
  logic [N-1:0]    m_we_i;
  logic [4*N-1:0]  m_sel_i;
  logic [32*N-1:0] m_adr_i;
  logic [32*N-1:0] m_dat_i;
  logic [N-1:0]    m_ack_o;
  logic [N-1:0]    m_err_o;
  logic [31:0]     m_dat_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic            s_we_o;
  logic [3:0]      s_sel_o;
  logic [31:0]     s_adr_o;
  logic [31:0]     s_dat_o;
  logic            s_ack_i;
  logic [31:0]     s_dat_i;
  logic [N-1:0]    grant_o;
  logic            timeout_irq_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o,
           s_dat_o, grant_o, timeout_irq_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o,
           s_dat_o, grant_o, timeout_irq_o
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone B4 classic arbiter: round-robin per bus cycle, grant locked
// for the whole CYC, with a per-beat ACK watchdog that terminates stalled beats with ERR.
module wb_rr_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_rr_arbiter_if.slave bus
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  state_t        state_q;
  logic [N-1:0]  grant_q;
  logic [GW-1:0] last_q;   // doubles as the index of the current owner while in ST_GRANT
  logic [WW-1:0] wd_q;

  logic [N-1:0]  req;
  logic [GW-1:0] pick;
  logic          pick_vld;
  logic [3:0]    sel_arr [N];
  logic [31:0]   adr_arr [N];
  logic [31:0]   dat_arr [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign req[gi]     = bus.m_cyc_i[gi] & bus.m_stb_i[gi];
      assign sel_arr[gi] = bus.m_sel_i[4*gi +: 4];
      assign adr_arr[gi] = bus.m_adr_i[32*gi +: 32];
      assign dat_arr[gi] = bus.m_dat_i[32*gi +: 32];
    end
  endgenerate

  // Scan from farthest to nearest so the requester closest after last_q is the final winner.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last_q) + i) % N]) begin
        pick     = GW'((int'(last_q) + i) % N);
        pick_vld = 1'b1;
      end
    end
  end

  logic granted;
  logic g_cyc;
  logic g_stb;
  logic stalled;
  logic expire;

  assign granted = (state_q == ST_GRANT);
  assign g_cyc   = granted & bus.m_cyc_i[last_q];
  assign g_stb   = granted & bus.m_stb_i[last_q];
  assign stalled = g_stb & ~bus.s_ack_i;
  // A same-cycle ACK removes the stall, so ACK always beats the watchdog.
  assign expire  = (TIMEOUT != 0) & stalled & (wd_q == WD_MAX);

  assign bus.s_cyc_o       = g_cyc;
  assign bus.s_stb_o       = g_stb & ~expire;
  assign bus.s_we_o        = granted & bus.m_we_i[last_q];
  assign bus.s_sel_o       = granted ? sel_arr[last_q] : 4'h0;
  assign bus.s_adr_o       = granted ? adr_arr[last_q] : 32'h0;
  assign bus.s_dat_o       = granted ? dat_arr[last_q] : 32'h0;
  assign bus.m_ack_o       = (g_stb & bus.s_ack_i) ? grant_q : '0;
  assign bus.m_err_o       = expire ? grant_q : '0;
  assign bus.m_dat_o       = expire ? 32'hDEADBEEF : (granted ? bus.s_dat_i : 32'h0);
  assign bus.grant_o       = grant_q;
  assign bus.timeout_irq_o = expire;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N - 1);
      wd_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          wd_q <= '0;
          if (pick_vld) begin
            state_q <= ST_GRANT;
            last_q  <= pick;
            grant_q <= N'(1) << pick;
          end
        end
        ST_GRANT: begin
          if (!stalled || expire) begin
            wd_q <= '0;
          end else if (wd_q != WD_MAX) begin
            wd_q <= wd_q + 1'b1;
          end
          if (!bus.m_cyc_i[last_q]) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
